nmr_voter: RTL

NMR_VOTER -- requirements
Module: nmr_voter

---
 rtl/tmr_pkg.sv | 21 ++
 rtl/nmr_fault_tracker.sv | 52 +++++
 rtl/nmr_voter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and defaults for the N-modular-redundancy voter.
// FSM encoding, parameter defaults and a small popcount helper.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_DEGRADED,
    ST_HOLD,
    ST_FATAL
  } vstate_t;

  localparam int W_DEF            = 97;
  localparam int CNT_W_DEF        = 8;
  localparam int FAULT_THRESH_DEF = 4;
  localparam int HOLD_MAX_DEF     = 8;

  function automatic logic [1:0] pop3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/nmr_fault_tracker.sv
// Per-core dissent bookkeeping: total errors, consecutive run, failed flag.
// fail_nxt exposes the flag value the next edge will load.
module nmr_fault_tracker
  import tmr_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FAULT_THRESH = FAULT_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dissent,
  input  logic             agree,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             failed,
  output logic             fail_nxt
);

  localparam int CW = $clog2(FAULT_THRESH + 1);

  logic [CW-1:0] consec;
  logic          hit;

  assign hit = dissent && !failed &&
               (consec == CW'(FAULT_THRESH - 1));
  assign fail_nxt = !clr && (failed || hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      consec  <= '0;
      failed  <= 1'b0;
    end else begin
      if (dissent && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
      // clear wins over a threshold crossing on the same edge
      if (clr) begin
        consec <= '0;
        failed <= 1'b0;
      end else begin
        failed <= fail_nxt;
        if (dissent) begin
          if (consec != CW'(FAULT_THRESH))
            consec <= consec + 1'b1;
        end else if (agree && !failed) begin
          consec <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/nmr_voter.sv
// Triple-core majority voter with fault tracking and hold/fatal escalation.
// Output is registered; core_hold is combinational for same-cycle stalls.
module nmr_voter
  import tmr_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FAULT_THRESH = FAULT_THRESH_DEF,
  parameter int HOLD_MAX     = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             in_valid,
  input  logic [W-1:0]     bundle_a,
  input  logic [W-1:0]     bundle_b,
  input  logic [W-1:0]     bundle_c,
  input  logic             fail_clr,
  output logic [W-1:0]     out_bundle,
  output logic             out_valid,
  output logic [2:0]       voter_state,
  output logic             core_hold,
  output logic [2:0]       core_failed,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic             fatal
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  vstate_t       state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  logic eq_ab, eq_bc, eq_ac;
  logic ab_u, bc_u, ac_u;
  logic sel_a, sel_b, have_sel;
  logic live, vote, clr, all_ok;
  logic dis_a, dis_b, dis_c;
  logic agr_a, agr_b, agr_c;
  logic [2:0] fail_nxt;
  logic [W-1:0] sel_bundle;
  vstate_t base_st;

  assign eq_ab = (bundle_a == bundle_b);
  assign eq_bc = (bundle_b == bundle_c);
  assign eq_ac = (bundle_a == bundle_c);

  assign ab_u = eq_ab && !core_failed[0] && !core_failed[1];
  assign bc_u = eq_bc && !core_failed[1] && !core_failed[2];
  assign ac_u = eq_ac && !core_failed[0] && !core_failed[2];

  assign sel_a      = ab_u || ac_u;
  assign sel_b      = !sel_a && bc_u;
  assign have_sel   = sel_a || sel_b;
  assign sel_bundle = sel_a ? bundle_a : bundle_b;

  assign live   = (state != ST_FATAL);
  assign vote   = in_valid && live;
  assign clr    = fail_clr && live;
  assign all_ok = (core_failed == 3'b000);

  // a lone agreeing pair charges the odd core out
  assign dis_a = vote && all_ok && eq_bc && !eq_ab && !eq_ac;
  assign dis_b = vote && all_ok && eq_ac && !eq_ab && !eq_bc;
  assign dis_c = vote && all_ok && eq_ab && !eq_bc && !eq_ac;

  assign agr_a = vote && (sel_a || (sel_b && eq_ab));
  assign agr_b = vote && (sel_b || (sel_a && eq_ab));
  assign agr_c = vote && ((sel_a && eq_ac) || (sel_b && eq_bc));

  nmr_fault_tracker #(
    .CNT_W        (CNT_W),
    .FAULT_THRESH (FAULT_THRESH)
  ) u_trk_a (
    .clk      (clk),
    .rst_n    (rst_in),
    .dissent  (dis_a),
    .agree    (agr_a),
    .clr      (clr),
    .err_cnt  (err_cnt_a),
    .failed   (core_failed[0]),
    .fail_nxt (fail_nxt[0])
  );

  nmr_fault_tracker #(
    .CNT_W        (CNT_W),
    .FAULT_THRESH (FAULT_THRESH)
  ) u_trk_b (
    .clk      (clk),
    .rst_n    (rst_in),
    .dissent  (dis_b),
    .agree    (agr_b),
    .clr      (clr),
    .err_cnt  (err_cnt_b),
    .failed   (core_failed[1]),
    .fail_nxt (fail_nxt[1])
  );

  nmr_fault_tracker #(
    .CNT_W        (CNT_W),
    .FAULT_THRESH (FAULT_THRESH)
  ) u_trk_c (
    .clk      (clk),
    .rst_n    (rst_in),
    .dissent  (dis_c),
    .agree    (agr_c),
    .clr      (clr),
    .err_cnt  (err_cnt_c),
    .failed   (core_failed[2]),
    .fail_nxt (fail_nxt[2])
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    base_st   = (pop3(fail_nxt) == 2'd0) ? ST_NORMAL : ST_DEGRADED;
    if (state != ST_FATAL) begin
      if (pop3(fail_nxt) >= 2'd2) begin
        state_nxt = ST_FATAL;
      end else if (clr) begin
        state_nxt = ST_NORMAL;
        hold_nxt  = '0;
      end else if (state == ST_HOLD) begin
        if (in_valid) begin
          if (have_sel) begin
            state_nxt = base_st;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
            if (({1'b0, hold_cnt} + 1'b1) >= (HW + 1)'(HOLD_MAX))
              state_nxt = ST_FATAL;
          end
        end
      end else if (in_valid && !have_sel) begin
        state_nxt = ST_HOLD;
      end else begin
        state_nxt = base_st;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state       <= ST_NORMAL;
      hold_cnt    <= '0;
      out_bundle  <= '0;
      out_valid   <= 1'b0;
      voter_state <= 3'b000;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      out_valid <= vote && have_sel;
      if (vote && have_sel)
        out_bundle <= sel_bundle;
      if (in_valid)
        voter_state <= {eq_ab, eq_bc, eq_ac};
    end
  end

  assign fatal = (state == ST_FATAL);

  // gated by reset so the stall request drops with rst_in, not a clock
  assign core_hold = rst_in &&
                     ((state == ST_HOLD) || (state == ST_FATAL) ||
                      (in_valid && !have_sel));

endmodule
